// File: rtl/mux_rr_n.sv
// Registered N:1 multiplexer with per-channel valid/ready handshake, selecting
// either a fixed channel (sel_in) or the next requester in round-robin order.
// Ports:
//   clock, reset              - rising-edge clock, async active-high reset
//   data_in/valid_in          - CHANNELS packed words (channel k at [k*WIDTH +: WIDTH]) and their valids
//   ready_out                 - one-hot (or zero) acceptance, combinational from ready_in/valid_in/mode/sel
//   mode_in, sel_in           - 0: fixed channel sel_in, 1: round-robin after the last served channel
//   data_out/valid_out/ch_out - one-stage output register and the channel that supplied it
//   ready_in                  - consumer accepts data_out this cycle
module mux_rr_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       valid_in,
  output logic [CHANNELS-1:0]       ready_out,
  input  logic                      mode_in,
  input  logic [SEL_W-1:0]          sel_in,
  output logic [WIDTH-1:0]          data_out,
  output logic                      valid_out,
  output logic [SEL_W-1:0]          ch_out,
  input  logic                      ready_in
);

  // One extra bit so last_q + offset never overflows before the wrap.
  localparam logic [SEL_W:0]   NCH      = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(CHANNELS-1);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [SEL_W-1:0] last_q, last_d;

  logic             load_en;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt;
  logic [WIDTH-1:0] gnt_data;
  logic [SEL_W:0]   cand;

  // The register can take a word when it is empty or being drained this cycle.
  assign load_en = !valid_q || ready_in;

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    cand    = '0;
    if (mode_in) begin
      // Search last_q+1, last_q+2, ... wrapping at CHANNELS-1, ending on last_q.
      // Indices at or above CHANNELS are never produced.
      for (int i = 1; i <= CHANNELS; i++) begin
        cand = {1'b0, last_q} + (SEL_W+1)'(i);
        if (cand >= NCH) begin
          cand = cand - NCH;
        end
        if (!gnt_vld && valid_in[cand[SEL_W-1:0]]) begin
          gnt_vld = 1'b1;
          gnt     = cand[SEL_W-1:0];
        end
      end
    end else begin
      if ({1'b0, sel_in} < NCH) begin
        if (valid_in[sel_in]) begin
          gnt_vld = 1'b1;
          gnt     = sel_in;
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (gnt == SEL_W'(k)) begin
        gnt_data = data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  // Gated by reset so no channel sees an acceptance while the block is held.
  always_comb begin
    ready_out = '0;
    if (!reset && load_en && gnt_vld) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (gnt == SEL_W'(k)) begin
          ready_out[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ch_d    = ch_q;
    last_d  = last_q;
    if (load_en && gnt_vld) begin
      // A new word overwrites the one being drained in the same edge.
      data_d  = gnt_data;
      valid_d = 1'b1;
      ch_d    = gnt;
      last_d  = gnt;
    end else if (valid_q && ready_in) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
      last_q  <= LAST_RST;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign ch_out    = ch_q;

endmodule

// File: tb/tb_mux_rr_n.sv
module tb_mux_rr_n;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Index 0: default 4-channel, 8-bit instance. Index 1: 3-channel, 16-bit instance.
  logic [3:0]  st_valid [2];
  logic [15:0] st_dat   [2][4];
  logic        st_mode  [2];
  logic [1:0]  st_sel   [2];
  logic        st_rdy   [2];

  logic [31:0] d4_data;
  logic [3:0]  d4_ready;
  logic [7:0]  d4_dout;
  logic        d4_vout;
  logic [1:0]  d4_ch;

  logic [47:0] d3_data;
  logic [2:0]  d3_ready;
  logic [15:0] d3_dout;
  logic        d3_vout;
  logic [1:0]  d3_ch;

  always_comb begin
    for (int k = 0; k < 4; k++) d4_data[k*8 +: 8] = st_dat[0][k][7:0];
    for (int k = 0; k < 3; k++) d3_data[k*16 +: 16] = st_dat[1][k];
  end

  mux_rr_n u_dut4 (
    .clock(clock), .reset(reset),
    .data_in(d4_data), .valid_in(st_valid[0]), .ready_out(d4_ready),
    .mode_in(st_mode[0]), .sel_in(st_sel[0]),
    .data_out(d4_dout), .valid_out(d4_vout), .ch_out(d4_ch),
    .ready_in(st_rdy[0])
  );

  mux_rr_n #(.WIDTH(16), .CHANNELS(3), .SEL_W(2)) u_dut3 (
    .clock(clock), .reset(reset),
    .data_in(d3_data), .valid_in(st_valid[1][2:0]), .ready_out(d3_ready),
    .mode_in(st_mode[1]), .sel_in(st_sel[1]),
    .data_out(d3_dout), .valid_out(d3_vout), .ch_out(d3_ch),
    .ready_in(st_rdy[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference model: output slot contents and the last channel served.
  int          nch    [2] = '{4, 3};
  int          m_vld  [2];
  int          m_ch   [2];
  int          m_last [2];
  logic [15:0] m_dat  [2];

  function automatic int model_grant(int d);
    int n;
    n = nch[d];
    if (st_mode[d]) begin
      for (int off = 1; off <= n; off++) begin
        if (st_valid[d][(m_last[d] + off) % n]) return (m_last[d] + off) % n;
      end
      return -1;
    end
    if (int'(st_sel[d]) < n) begin
      if (st_valid[d][st_sel[d]]) return int'(st_sel[d]);
    end
    return -1;
  endfunction

  function automatic logic [31:0] obs_ready(int d);
    return (d == 0) ? 32'(d4_ready) : 32'(d3_ready);
  endfunction
  function automatic logic [31:0] obs_data(int d);
    return (d == 0) ? 32'(d4_dout) : 32'(d3_dout);
  endfunction
  function automatic logic [31:0] obs_vld(int d);
    return (d == 0) ? 32'(d4_vout) : 32'(d3_vout);
  endfunction
  function automatic logic [31:0] obs_ch(int d);
    return (d == 0) ? 32'(d4_ch) : 32'(d3_ch);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_vld[d]  = 0;
      m_ch[d]   = 0;
      m_dat[d]  = '0;
      m_last[d] = nch[d] - 1;
    end
  endtask

  // Entered just after a falling edge with inputs already driven.
  task automatic cycle();
    int   g [2];
    logic ld;
    logic [31:0] exp_r;
    #1;
    for (int d = 0; d < 2; d++) begin
      g[d]  = model_grant(d);
      ld    = (m_vld[d] == 0) || st_rdy[d];
      exp_r = (ld && g[d] >= 0) ? (32'd1 << g[d]) : 32'd0;
      chk($sformatf("ready_out_n%0d", nch[d]), obs_ready(d), exp_r);
    end
    @(posedge clock);
    for (int d = 0; d < 2; d++) begin
      ld = (m_vld[d] == 0) || st_rdy[d];
      if (ld && g[d] >= 0) begin
        m_dat[d]  = st_dat[d][g[d]] & ((d == 0) ? 16'h00ff : 16'hffff);
        m_ch[d]   = g[d];
        m_vld[d]  = 1;
        m_last[d] = g[d];
      end else if (m_vld[d] != 0 && st_rdy[d]) begin
        m_vld[d] = 0;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("valid_out_n%0d", nch[d]), obs_vld(d), 32'(m_vld[d]));
      chk($sformatf("ch_out_n%0d", nch[d]), obs_ch(d), 32'(m_ch[d]));
      chk($sformatf("data_out_n%0d", nch[d]), obs_data(d), 32'(m_dat[d]));
    end
    @(negedge clock);
  endtask

  // Asserts reset asynchronously (between edges) and checks the cleared state.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      chk("rst_data", obs_data(d), 32'd0);
      chk("rst_valid", obs_vld(d), 32'd0);
      chk("rst_ch", obs_ch(d), 32'd0);
      chk("rst_ready", obs_ready(d), 32'd0);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic set_all(input logic [3:0] v, input logic mode, input logic [1:0] sel, input logic rdy);
    for (int d = 0; d < 2; d++) begin
      st_valid[d] = v;
      st_mode[d]  = mode;
      st_sel[d]   = sel;
      st_rdy[d]   = rdy;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq4 [5];
    int seq3 [5];
    int sp   [6];
    seq4 = '{0, 1, 2, 3, 0};
    seq3 = '{0, 1, 2, 0, 1};
    sp   = '{1, 3, 1, 3, 1, 1};
    for (int k = 0; k < 4; k++) begin
      st_dat[0][k] = 16'(8'h10 + k);
      st_dat[1][k] = 16'(16'h0100 + k);
    end
    set_all(4'b0000, 1'b0, 2'd0, 1'b0);
    model_reset();
    @(negedge clock);
    do_reset();

    // Park a word in the output register, then reset while it is pending
    // and while every channel still requests.
    set_all(4'b1111, 1'b1, 2'd0, 1'b0);
    cycle();
    chk("pending_valid", 32'(d4_vout), 32'd1);
    do_reset();

    // Round-robin over all channels at full throughput; 3-channel wraps at 2.
    set_all(4'b1111, 1'b1, 2'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("rr4_seq", 32'(d4_ch), 32'(seq4[i]));
      chk("rr4_valid", 32'(d4_vout), 32'd1);
      chk("rr4_data", 32'(d4_dout), 32'(8'h10 + seq4[i]));
      chk("rr3_seq", 32'(d3_ch), 32'(seq3[i]));
    end

    // Sparse requesters 1 and 3, then channel 1 alone.
    for (int i = 0; i < 6; i++) begin
      st_valid[0] = (i < 4) ? 4'b1010 : 4'b0010;
      cycle();
      chk("sparse_seq", 32'(d4_ch), 32'(sp[i]));
    end

    // Fixed select of channel 2, then channel 2 drops its request.
    set_all(4'b1111, 1'b0, 2'd2, 1'b1);
    cycle();
    chk("fix_ch", 32'(d4_ch), 32'd2);
    chk("fix_data", 32'(d4_dout), 32'h12);
    st_valid[0] = 4'b1011;
    cycle();
    chk("fix_drain", 32'(d4_vout), 32'd0);

    // Serve 2 in fixed mode, then switch to round-robin: 3 then 0.
    set_all(4'b1111, 1'b0, 2'd2, 1'b1);
    cycle();
    chk("sw_fixed", 32'(d4_ch), 32'd2);
    set_all(4'b1111, 1'b1, 2'd0, 1'b1);
    cycle();
    chk("sw_rr_a", 32'(d4_ch), 32'd3);
    cycle();
    chk("sw_rr_b", 32'(d4_ch), 32'd0);

    // Stall three cycles while mode/sel wiggle, then release.
    set_all(4'b1111, 1'b1, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      st_mode[0] = (i == 1) ? 1'b0 : 1'b1;
      st_sel[0]  = 2'(i + 1);
      cycle();
      chk("stall_ch", 32'(d4_ch), 32'd0);
      chk("stall_data", 32'(d4_dout), 32'h10);
    end
    set_all(4'b1111, 1'b1, 2'd0, 1'b1);
    cycle();
    chk("release_ch", 32'(d4_ch), 32'd1);

    // Randomised traffic on both instances against the model.
    for (int i = 0; i < 400; i++) begin
      for (int d = 0; d < 2; d++) begin
        st_valid[d] = 4'($urandom);
        st_mode[d]  = 1'($urandom_range(0, 1));
        st_sel[d]   = 2'($urandom_range(0, 3));
        st_rdy[d]   = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < 4; k++) begin
          st_dat[d][k] = (d == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
        end
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_rr_n.md
# mux_rr_n

Parametrised, registered N:1 multiplexer with per-channel valid/ready handshake and a selectable arbitration mode. It selects between externally driven fixed selection and fair round-robin among requesting channels. It also adds a one-stage output register with backpressure. It sits where the datapath previously used combinational 2:1/4:1 muxing and now needs flow control between several producers and one consumer.

## Interface
- WIDTH, 8, data width of each channel.
- CHANNELS, 4, number of input channels (≥2).
- SEL_W, 2, select/channel-index width; must equal $clog2(CHANNELS).

- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- valid_in  input  CHANNELS  channel k has data on data_in.
- ready_out  output  CHANNELS  channel k's data is accepted this cycle (one-hot or zero).
- mode_in  input  1  0 = fixed select via sel_in, 1 = round-robin.
- sel_in  input  SEL_W  channel index used when mode_in=0.
- data_out  output  WIDTH  registered selected data.
- valid_out  output  1  data_out holds an unconsumed word.
- ch_out  output  SEL_W  index of the channel that supplied data_out.
- ready_in  input  1  consumer accepts data_out this cycle.

## Operation
- One clock, asynchronous active-high reset. All state updates on the rising clock edge.
- Output register state: data_out, valid_out, ch_out. Round-robin pointer: last_ch, SEL_W bits.
- load_en = !valid_out || ready_in. This is a combinational path from ready_in to ready_out, which is intentional.
- Grant, evaluated combinationally each cycle:
  - mode_in=0: grant channel sel_in if sel_in < CHANNELS and valid_in[sel_in]=1; otherwise no grant. Other valid channels are ignored.
  - mode_in=1: grant the first channel with valid_in=1, searching last_ch+1, last_ch+2, … with wrap modulo CHANNELS, ending at last_ch itself. Grant nothing if valid_in is all zero.
- ready_out[g]=1 only for the granted channel g, and only when load_en=1. All other bits are 0.
- Transfer in, when load_en and a grant exist:
  - data_out ← data_in[g], ch_out ← g, valid_out ← 1, last_ch ← g.
  - last_ch updates in both modes, so round-robin resumes after the last-served channel when the mode is switched.
- Transfer out: valid_out && ready_in. If there is no new grant in the same cycle, valid_out ← 0 and data_out/ch_out hold their old value.
- Simultaneous out and in: a new word replaces the old one in the same edge, giving full throughput of 1 word/cycle.
- Stall: valid_out=1 and ready_in=0. Output register, ch_out and last_ch hold; ready_out is all zero.
- mode_in and sel_in are sampled every cycle. Changing them while stalled does not alter the held output word.
- Non-power-of-two CHANNELS: wrap is at CHANNELS-1 → 0, never to unused indices.

## Timing
- Reset values: data_out=0, valid_out=0, ch_out=0, last_ch=CHANNELS-1, ready_out=0 while reset is asserted. After reset, the first round-robin search starts at channel 0.
- Latency: valid_in/data_in accepted at edge N appear on data_out/valid_out after edge N, i.e. one cycle.
- Handshake: a word moves in on a cycle where valid_in[k] && ready_out[k]. It moves out on a cycle where valid_out && ready_in. Both are evaluated before the edge.
- Reset asserted mid-transfer: the output word is discarded immediately (asynchronous). No ready_out is asserted during reset.
- ready_out is combinational from valid_in, mode_in, sel_in, ready_in and the state. No register is on that path.

## Test plan
- Reset and first word: assert reset with valid_out=1 pending, then release. Expect data_out=0, valid_out=0, ch_out=0. Next, drive mode_in=1, all four valid_in=1 with data 0x10,0x11,0x12,0x13, ready_in=1. Expect ch_out sequence 0,1,2,3,0 on consecutive cycles and valid_out constantly 1.
- Sparse round-robin: mode_in=1, valid_in=4'b1010, ready_in=1. Expect grants alternating 1,3,1,3. Then drop valid_in[3] and expect channel 1 on every cycle.
- Fixed mode: mode_in=0, sel_in=2, valid_in=4'b1111. Expect only ready_out[2]=1 and data_out=data_in[2]. With valid_in[2]=0, expect ready_out=0 and valid_out falling after one consumed word.
- Backpressure: mode_in=1, hold ready_in=0 for 3 cycles with valid_out=1. Expect data_out/ch_out stable and ready_out=0. Release ready_in and expect the next grant from last_ch+1 on the same cycle.
- Mode switch: serve channel 2 in fixed mode, then switch to mode_in=1 with all valid. Expect the next grant to go to channel 3, then 0.
- Parameter sweep: CHANNELS=3, WIDTH=16, all valid. Expect the grant order 0,1,2,0 with no index 3 ever produced.
